// File: rtl/mem_port_arb_if.sv
// Bundle of core-side request/response signals and RAM command signals for mem_port_arb.
// No storage of its own; timing is defined by the arbiter using the slave modport.
// Requesters hold req/payload until their grant; the arbiter applies no other backpressure.
interface mem_port_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // LSU data port
  logic              lsu_req_i;
  logic              lsu_we_i;
  logic [3:0]        lsu_sel_i;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic [DATA_W-1:0] lsu_wdata_i;
  logic              lsu_gnt_o;
  logic              lsu_rvalid_o;
  logic [DATA_W-1:0] lsu_rdata_o;
  // instruction-fetch port
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  // RAM command/response
  logic              mem_ce_o;
  logic              mem_we_o;
  logic [3:0]        mem_sel_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  // arbiter view
  modport slave (
    input  lsu_req_i, lsu_we_i, lsu_sel_i, lsu_addr_i, lsu_wdata_i,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  // core + RAM view
  modport master (
    output lsu_req_i, lsu_we_i, lsu_sel_i, lsu_addr_i, lsu_wdata_i,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/mem_port_arb.sv
// Shares one synchronous-read RAM between LSU and fetch: LSU priority, fetch starvation guard.
// Grant and RAM command are combinational; read data returns one cycle after the grant.
// Loser is not granted and must hold its request; no internal queueing.
module mem_port_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic           ck_i,
  input logic           rst_n_i,
  mem_port_arb_if.slave bus
);

  localparam logic [DATA_W-1:0] NOP      = DATA_W'(32'h0000_0013);
  localparam logic [3:0]        STARVE_T = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LSU  = 2'd1,
    OWN_IF   = 2'd2
  } owner_t;

  owner_t     owner;
  logic       lsu_rvalid_q;
  logic       if_rvalid_q;
  logic [3:0] starve_cnt;

  logic both_req;
  logic if_wins;
  logic lsu_gnt;
  logic if_gnt;

  // Winner selection; grants are forced low while reset is asserted
  always_comb begin
    both_req = bus.lsu_req_i & bus.if_req_i;
    if_wins  = both_req && (starve_cnt == STARVE_T);
    lsu_gnt  = rst_n_i && bus.lsu_req_i && !if_wins;
    if_gnt   = rst_n_i && bus.if_req_i && (!bus.lsu_req_i || if_wins);
  end

  // RAM command driven straight from the winner; fetch is always a word-aligned full read
  always_comb begin
    bus.mem_ce_o    = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_sel_o   = 4'h0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (lsu_gnt) begin
      bus.mem_ce_o    = 1'b1;
      bus.mem_we_o    = bus.lsu_we_i;
      bus.mem_sel_o   = bus.lsu_sel_i;
      bus.mem_addr_o  = bus.lsu_addr_i;
      bus.mem_wdata_o = bus.lsu_wdata_i;
    end else if (if_gnt) begin
      bus.mem_ce_o   = 1'b1;
      bus.mem_sel_o  = 4'hF;
      bus.mem_addr_o = {bus.if_addr_i[ADDR_W-1:2], 2'b00};
    end
  end

  // Count consecutive contended LSU wins; any fetch grant or idle fetch restarts the count
  always_ff @(posedge ck_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_cnt <= 4'd0;
    end else if (!bus.if_req_i || if_gnt) begin
      starve_cnt <= 4'd0;
    end else if (lsu_gnt && starve_cnt < STARVE_T) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Response owner FSM: tracks who gets the RAM data next cycle; writes produce no response
  always_ff @(posedge ck_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      owner        <= OWN_NONE;
      lsu_rvalid_q <= 1'b0;
      if_rvalid_q  <= 1'b0;
    end else begin
      if (lsu_gnt && !bus.lsu_we_i) begin
        owner        <= OWN_LSU;
        lsu_rvalid_q <= 1'b1;
        if_rvalid_q  <= 1'b0;
      end else if (if_gnt) begin
        owner        <= OWN_IF;
        lsu_rvalid_q <= 1'b0;
        if_rvalid_q  <= 1'b1;
      end else begin
        owner        <= OWN_NONE;
        lsu_rvalid_q <= 1'b0;
        if_rvalid_q  <= 1'b0;
      end
    end
  end

  // Route RAM data to the owning port only; idle fetch data reads as NOP
  always_comb begin
    bus.lsu_gnt_o    = lsu_gnt;
    bus.if_gnt_o     = if_gnt;
    bus.lsu_rvalid_o = lsu_rvalid_q;
    bus.if_rvalid_o  = if_rvalid_q;
    bus.lsu_rdata_o  = lsu_rvalid_q ? bus.mem_rdata_i : '0;
    bus.if_rdata_o   = if_rvalid_q  ? bus.mem_rdata_i : NOP;
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with a small byte-enabled synchronous RAM.
// Expected values are hand-computed constants.
// Summary line reports errors against total checks.
module tb_mem_port_arb;

  logic ck = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 ck = ~ck;

  mem_port_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arb #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .ck_i    (ck),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  // RAM macro: synchronous read, byte-enabled write
  logic [31:0] ram [0:63];
  logic [31:0] ram_q = 32'h0;
  always @(posedge ck) begin
    if (bus.mem_ce_o) begin
      if (bus.mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_sel_o[b]) ram[bus.mem_addr_o[7:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
      end else begin
        ram_q <= ram[bus.mem_addr_o[7:2]];
      end
    end
  end
  assign bus.mem_rdata_i = ram_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic lreq, input logic lwe, input logic [3:0] lsel,
                       input logic [31:0] laddr, input logic [31:0] lwd,
                       input logic ireq, input logic [31:0] iaddr);
    bus.lsu_req_i   = lreq;
    bus.lsu_we_i    = lwe;
    bus.lsu_sel_i   = lsel;
    bus.lsu_addr_i  = laddr;
    bus.lsu_wdata_i = lwd;
    bus.if_req_i    = ireq;
    bus.if_addr_i   = iaddr;
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  // LSU reads 0x20 and fetch reads 0x10 while both contend; pattern 1 = LSU wins
  task automatic contend(input int n, input string tag);
    int pat[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    drive(1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b1, 32'h10);
    for (int i = 0; i < n; i++) begin
      #1;
      chk({tag, "_lsu_gnt"}, 32'(bus.lsu_gnt_o), 32'(pat[i]));
      chk({tag, "_if_gnt"}, 32'(bus.if_gnt_o), 32'(pat[i] == 0));
      tick();
      chk({tag, "_lsu_rvalid"}, 32'(bus.lsu_rvalid_o), 32'(pat[i]));
      chk({tag, "_if_rvalid"}, 32'(bus.if_rvalid_o), 32'(pat[i] == 0));
      if (pat[i] == 1) chk({tag, "_lsu_rdata"}, bus.lsu_rdata_o, 32'hAABB_5678);
      else begin
        chk({tag, "_if_rdata"}, bus.if_rdata_o, 32'hDEAD_BEEF);
        chk({tag, "_lsu_rdata_idle"}, bus.lsu_rdata_o, 32'h0);
      end
    end
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    ram[4] = 32'hDEAD_BEEF;
    ram[8] = 32'hAABB_CCDD;

    // reset: requests present but nothing granted
    drive(1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b1, 32'h10);
    #12;
    chk("rst_lsu_gnt", 32'(bus.lsu_gnt_o), 32'h0);
    chk("rst_if_gnt", 32'(bus.if_gnt_o), 32'h0);
    chk("rst_mem_ce", 32'(bus.mem_ce_o), 32'h0);
    chk("rst_lsu_rvalid", 32'(bus.lsu_rvalid_o), 32'h0);
    chk("rst_if_rvalid", 32'(bus.if_rvalid_o), 32'h0);
    chk("rst_lsu_rdata", bus.lsu_rdata_o, 32'h0);
    chk("rst_if_rdata", bus.if_rdata_o, 32'h13);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    #20 rst_n = 1'b1;
    tick();

    // single fetch
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h10);
    #1;
    chk("f_if_gnt", 32'(bus.if_gnt_o), 32'h1);
    chk("f_lsu_gnt", 32'(bus.lsu_gnt_o), 32'h0);
    chk("f_mem_ce", 32'(bus.mem_ce_o), 32'h1);
    chk("f_mem_we", 32'(bus.mem_we_o), 32'h0);
    chk("f_mem_sel", 32'(bus.mem_sel_o), 32'hF);
    chk("f_mem_addr", bus.mem_addr_o, 32'h10);
    tick();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("f_if_rvalid", 32'(bus.if_rvalid_o), 32'h1);
    chk("f_if_rdata", bus.if_rdata_o, 32'hDEAD_BEEF);
    chk("f_lsu_rvalid", 32'(bus.lsu_rvalid_o), 32'h0);
    tick();
    chk("f_idle_rvalid", 32'(bus.if_rvalid_o), 32'h0);
    chk("f_idle_nop", bus.if_rdata_o, 32'h13);

    // LSU partial write then read-back of merged word
    drive(1'b1, 1'b1, 4'b0011, 32'h20, 32'h1234_5678, 1'b0, 32'h0);
    #1;
    chk("w_lsu_gnt", 32'(bus.lsu_gnt_o), 32'h1);
    chk("w_mem_we", 32'(bus.mem_we_o), 32'h1);
    chk("w_mem_sel", 32'(bus.mem_sel_o), 32'h3);
    chk("w_mem_addr", bus.mem_addr_o, 32'h20);
    chk("w_mem_wdata", bus.mem_wdata_o, 32'h1234_5678);
    tick();
    drive(1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 32'h0);
    chk("w_no_rvalid", 32'(bus.lsu_rvalid_o), 32'h0);
    #1;
    chk("r_lsu_gnt", 32'(bus.lsu_gnt_o), 32'h1);
    chk("r_mem_we", 32'(bus.mem_we_o), 32'h0);
    tick();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("r_lsu_rvalid", 32'(bus.lsu_rvalid_o), 32'h1);
    chk("r_lsu_rdata", bus.lsu_rdata_o, 32'hAABB_5678);
    chk("r_if_rvalid", 32'(bus.if_rvalid_o), 32'h0);
    tick();

    // continuous contention: L,L,L,L,I repeating
    contend(10, "starve");
    tick();

    // alternating single requesters, one word per cycle
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) drive(1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 32'h0);
      else            drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h10);
      #1;
      chk("alt_lsu_gnt", 32'(bus.lsu_gnt_o), 32'(i % 2 == 0));
      chk("alt_if_gnt", 32'(bus.if_gnt_o), 32'(i % 2 == 1));
      tick();
      chk("alt_lsu_rvalid", 32'(bus.lsu_rvalid_o), 32'(i % 2 == 0));
      chk("alt_if_rvalid", 32'(bus.if_rvalid_o), 32'(i % 2 == 1));
      chk("alt_lsu_rdata", bus.lsu_rdata_o, (i % 2 == 0) ? 32'hAABB_5678 : 32'h0);
      chk("alt_if_rdata", bus.if_rdata_o, (i % 2 == 1) ? 32'hDEAD_BEEF : 32'h13);
    end
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();

    // unaligned fetch address is word-aligned on the RAM
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h13);
    #1;
    chk("ua_mem_addr", bus.mem_addr_o, 32'h10);
    tick();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("ua_if_rdata", bus.if_rdata_o, 32'hDEAD_BEEF);
    tick();

    // build up starve count, then reset with an LSU read in flight
    drive(1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b1, 32'h10);
    tick();
    tick();
    chk("ar_inflight", 32'(bus.lsu_rvalid_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rvalid_drop", 32'(bus.lsu_rvalid_o), 32'h0);
    chk("ar_gnt_low", 32'(bus.lsu_gnt_o), 32'h0);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    #3 rst_n = 1'b1;
    tick();
    chk("ar_post_lsu_rvalid", 32'(bus.lsu_rvalid_o), 32'h0);
    chk("ar_post_if_rvalid", 32'(bus.if_rvalid_o), 32'h0);
    // starve count restarts from zero: four LSU wins before fetch
    contend(5, "ar_starve");
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // hard bound on simulated time
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end

endmodule
